// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register with a two-entry skid buffer, synchronous flush
// and a saturating downstream-stall counter.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stat_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic in_xfer, out_xfer;
  logic load_main_in, load_main_skid, load_skid, clr_main;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Flush overrides every transition; the clearing of control fields is done in
  // the datapath so the load strobes here never fire on a flush cycle.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_main       = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            state_nxt    = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_xfer) begin
            clr_main  = 1'b1;
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            load_main_skid = 1'b1;
            state_nxt      = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end else if (clr_main) begin
        main_ctrl <= '0;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stat_clr)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: streaming, backpressure,
// flush, stall-counter saturation, drain and asynchronous reset.
module tb_pipe_stage_buf;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              stat_clr;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  pipe_stage_buf #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .stat_clr (stat_clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stat_clr = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_ctrl",  out_ctrl,  0);
    check("rst_out_data",  out_data,  0);
    check("rst_stall_cnt", stall_cnt, 0);
    reset = 1'b0;
    step();

    // streaming at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 8'h11;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      step();
      check("stream_data",  out_data,  64'(i));
      check("stream_valid", out_valid, 1);
      check("stream_ctrl",  out_ctrl,  8'h11);
      check("stream_ready", in_ready,  1);
    end
    // drain to empty
    in_valid = 1'b0;
    step();
    check("drain_valid", out_valid, 0);
    check("drain_ctrl",  out_ctrl,  0);
    check("drain_data",  out_data,  4);
    check("stream_stall", stall_cnt, 0);

    // backpressure
    in_valid = 1'b1; in_ctrl = 8'h22; in_data = 1;
    step();
    check("bp_first", out_data, 1);
    out_ready = 1'b0; in_data = 2;
    step();
    check("bp_full_ready", in_ready, 0);
    check("bp_hold1",      out_data, 1);
    in_data = 3;
    step();
    step();
    check("bp_hold_data", out_data, 1);
    check("bp_hold_rdy",  in_ready, 0);
    check("bp_stall",     stall_cnt, 3);
    out_ready = 1'b1;
    step();
    check("bp_out2",      out_data, 2);
    check("bp_ready_up",  in_ready, 1);
    step();
    check("bp_out3", out_data, 3);
    in_data = 4;
    step();
    check("bp_out4", out_data, 4);
    in_valid = 1'b0;
    step();
    check("bp_empty",       out_valid, 0);
    check("bp_stall_final", stall_cnt, 3);

    // flush while FULL with an input offered
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h33; in_data = 5;
    step();
    in_data = 6;
    step();
    check("fl_full", in_ready, 0);
    in_data = 9; flush = 1'b1;
    step();
    check("fl_valid", out_valid, 0);
    check("fl_ctrl",  out_ctrl,  0);
    check("fl_ready", in_ready,  1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no9", out_valid, 0);
    end
    check("fl_stall_kept", stall_cnt, 5);

    // stall counter saturation and clear
    stat_clr = 1'b1;
    step();
    check("cnt_clr0", stall_cnt, 0);
    stat_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h44; in_data = 7;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("cnt_sat", stall_cnt, 15);
    stat_clr = 1'b1;
    step();
    check("cnt_clr", stall_cnt, 0);
    stat_clr = 1'b0;
    step();
    check("cnt_resume", stall_cnt, 1);

    // asynchronous reset mid-stream while FULL
    in_valid = 1'b1; in_data = 8;
    step();
    check("ar_full", in_ready, 0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ctrl",  out_ctrl,  0);
    check("ar_data",  out_data,  0);
    check("ar_ready", in_ready,  1);
    check("ar_cnt",   stall_cnt, 0);
    #1;
    reset = 1'b0;
    step();
    check("ar_after", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline stage register for the processor pipeline, replacing fixed per-stage register banks (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a control field and a data field across a stage boundary under a valid/ready handshake. A two-entry skid buffer lets upstream run at full throughput while keeping `in_ready` registered. Synchronous flush inserts bubbles whose control bits are all-zero, and a saturating counter reports downstream stall cycles.

## Interface
- DATA_W, 32, width of the payload field (operands, PC, immediates).
- CTRL_W, 8, width of the control field (RegWrite, MemWrite, etc.); all-zero encodes a bubble.
- CNT_W, 16, width of the stall counter.
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clock clk.
- flush  input  1  synchronous; discard all held entries this cycle.
- stat_clr  input  1  synchronous clear of `stall_cnt`.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept an entry; depends only on registered state.
- in_ctrl  input  CTRL_W  upstream control field.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts the entry.
- out_ctrl  output  CTRL_W  control of the main entry; all-zero whenever `out_valid`=0.
- out_data  output  DATA_W  payload of the main entry; holds its last value when invalid.
- stall_cnt  output  CNT_W  cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Storage: main register (drives outputs) plus one skid register. State is EMPTY (no entries), BUSY (main only) or FULL (main and skid).
- `in_ready` = (state != FULL). Input transfer = `in_valid` & `in_ready`. Output transfer = `out_valid` & `out_ready`.
- EMPTY: input transfer loads main and moves to BUSY. Otherwise stays EMPTY.
- BUSY:
  - Input and output transfer: main is loaded from the input; stays BUSY.
  - Input transfer only: skid is loaded from the input; moves to FULL.
  - Output transfer only: moves to EMPTY.
  - Neither: holds.
- FULL: no input accepted. Output transfer moves skid into main and goes to BUSY. Otherwise holds.
- Ordering is strict FIFO; no entry is ever duplicated or dropped except by flush.
- Flush has the highest priority:
  - State goes to EMPTY.
  - Main and skid control fields are cleared to 0.
  - An input presented in the same cycle is discarded, even if `in_ready`=1.
  - An output transfer in the same cycle completes normally downstream; the entry is then gone.
- Whenever main becomes invalid, its control field is cleared to 0. Data fields are not cleared except by reset.
- stall_cnt:
  - Increments by 1 on each cycle with `out_valid` & !`out_ready`.
  - Saturates at 2^CNT_W−1.
  - `stat_clr` sets it to 0 and has priority over increment.
  - `flush` does not affect it.

## Timing
- Reset (asynchronous, immediate):
  - state EMPTY, `out_valid`=0, `in_ready`=1.
  - `out_ctrl`=0, `out_data`=0, skid contents 0, `stall_cnt`=0.
- Release of reset is synchronised externally; the first edge after deassertion may accept an input.
- Latency: an input accepted at edge N appears on `out_*` after edge N (1 cycle), when the stage was EMPTY or BUSY with a simultaneous output transfer.
- Throughput: 1 entry/cycle sustained when `out_ready`=1.
- After `out_ready` drops, at most one further input is accepted (into skid); `in_ready` falls the cycle after.
- After `out_ready` returns, `in_ready` rises one cycle after the skid drains.
- Flush at edge N: `out_valid`=0 and `in_ready`=1 from edge N onward.
- All outputs except `in_ready` and `out_*` are registered. `in_ready` and `out_*` are decoded only from registered state, so there are no combinational in→out paths.

## Test plan
- Reset mid-stream: with state FULL, assert `reset` between edges → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=1 immediately, without waiting for a clock edge.
- Streaming: `out_ready`=1, in_data 1,2,3,4 on consecutive cycles with ctrl 8'h11 → out_data 1,2,3,4 one cycle later, back-to-back; `in_ready` stays 1; `stall_cnt`=0.
- Backpressure: `out_ready`=0 from cycle 2 while feeding 1..4 → stage accepts 1 and 2, `in_ready`=0 after that; `out_data` holds 1. Releasing `out_ready` then delivers 1,2,3,4 in order; `stall_cnt` equals the number of held cycles.
- Flush while FULL with `in_valid`=1 (data 9) → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1; entry 9 never appears at the output.
- Counter: CNT_W=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_cnt` saturates at 15. Pulsing `stat_clr` → 0, and the count resumes at 1 on the next stalled cycle.
- Drain to empty: BUSY with `in_valid`=0 and `out_ready`=1 → `out_valid`=0, `out_ctrl`=0, `out_data` unchanged.
